mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer in front of the shared line-read data memory.
//  Port 0 is the I-cache refill path; port 1 is the D-cache refill/store path.
//  Selects one request at a time (round-robin) and drives the memory's WE, read-select and address.
//  Times read latency, qualifies READY, and returns the 512-bit line plus a 1-cycle done pulse.
// PARAMETERS
//  MIN_LAT   2   cycles in RD_WAIT before mem_ready is believed (masks stale READY from previous read)
//  TIMEOUT   63  max cycles in RD_WAIT before abort with err pulse; 6-bit counter
// PORTS
//  clk         in   1    clock, all state on posedge
//  rst         in   1    synchronous, active-high reset
//  req0/req1   in   1    request; held high until matching done
//  we0/we1     in   1    1 = word write, 0 = line read; sampled at grant
//  addr0/addr1 in   32   byte address; sampled at grant
//  wd0/wd1     in   32   write data; sampled at grant
//  done0/done1 out  1    1-cycle completion pulse
//  err         out  1    1-cycle timeout pulse (with done of the aborted port)
//  rline       out  512  line from last completed read; held until next read completes
//  mem_we      out  1    memory write enable
//  mem_rsel    out  4    memory read select (4'b0011 = line read, else 4'b0000)
//  mem_a       out  32   memory address
//  mem_wd      out  32   memory write data
//  mem_ready   in   1    memory line-valid flag
//  mem_rline   in   512  memory line data
// BEHAVIOUR
//  Reset: state=IDLE, last=1, cnt=0. All outputs 0, including rline, done*, err, mem_*.
//  States:
//   IDLE    -> WR when the granted port has we=1; -> RD_WAIT when we=0; stays IDLE if no req.
//   WR      mem_we=1, mem_a/mem_wd = latched values for 1 cycle -> DONE.
//   RD_WAIT mem_rsel=4'b0011, mem_a latched; cnt increments each cycle.
//           if cnt>=MIN_LAT && mem_ready: latch mem_rline into rline -> DONE.
//           else if cnt==TIMEOUT: err=1 -> DONE.
//   DONE    done pulse for the granted port; mem_rsel=0; cnt=0; last=granted -> IDLE.
//  Arbitration (IDLE only):
//   - A single requester wins.
//   - When both request, the port != last wins (strict alternation).
//   - Grant and latches (we, addr, wd) are taken on the IDLE->WR/RD_WAIT edge.
//  Latency:
//   - write = req seen to done is 3 cycles (IDLE, WR, DONE).
//   - read  = memory latency + 2 cycles.
//  Requester rules:
//   - A requester must drop req on the cycle after done.
//   - A req still high in IDLE after its done starts a new transaction.
//   - A req dropped mid-transaction does not abort it; done still pulses.
//  mem_ready is ignored in IDLE, WR and DONE, and while cnt<MIN_LAT.
//  done0 and done1 are never high together; err is only ever high with a done.
//  rst mid-transaction returns to IDLE next edge:
//   - no done pulse
//   - mem_we and mem_rsel drop
//   - rline clears.
//  cnt saturates at TIMEOUT and never wraps.
// TESTING
//  T1: rst then req1 we=1 addr=0x40 wd=0xDEADBEEF -> mem_we=1 for exactly one cycle with mem_a=0x40;
//      done1 two cycles after grant.
//  T2: req0 read addr=0x80, model READY after 20 cycles, line word0=0x11 -> rline[31:0]=0x11;
//      done0 on cycle 22 after grant.
//  T3: req0 and req1 both held high from reset -> grant order 0,1,0,1; never two done in one cycle.
//  T4: mem_ready stuck high from prior read, new read issued -> no completion before cnt=MIN_LAT.
//  T5: mem_ready never asserted -> err and done0 on cycle TIMEOUT+2 after grant; back to IDLE.
//  T6: rst asserted mid RD_WAIT -> next cycle IDLE, mem_rsel=0, rline=0, no done pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer between the I-cache and D-cache refill ports
// and the shared line-read memory; times read latency and reports timeouts.
module mem_arbiter #(
    parameter int MIN_LAT = 2,
    parameter int TIMEOUT = 63
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic         we0,
    input  logic         we1,
    input  logic [31:0]  addr0,
    input  logic [31:0]  addr1,
    input  logic [31:0]  wd0,
    input  logic [31:0]  wd1,
    output logic         done0,
    output logic         done1,
    output logic         err,
    output logic [511:0] rline,
    output logic         mem_we,
    output logic [3:0]   mem_rsel,
    output logic [31:0]  mem_a,
    output logic [31:0]  mem_wd,
    input  logic         mem_ready,
    input  logic [511:0] mem_rline
);

    // state   | meaning
    // IDLE    | waiting for a request, arbitration happens here
    // WR      | single-cycle word write to memory
    // RD_WAIT | line read outstanding, counting latency
    // DONE    | completion pulse to the granted port
    typedef enum logic [1:0] {IDLE, WR, RD_WAIT, DONE} state_t;

    localparam logic [5:0] MIN_LAT_C = 6'(MIN_LAT);
    localparam logic [5:0] TIMEOUT_C = 6'(TIMEOUT);

    state_t      state, state_nx;
    logic        last;
    logic        gnt;
    logic        gnt_sel;
    logic        we_sel;
    logic [31:0] addr_q;
    logic [31:0] wd_q;
    logic [5:0]  cnt;
    logic        timed_out;
    logic        ready_ok;

    // With both requesting, the port that did not win last time goes next.
    assign gnt_sel  = (req0 && req1) ? ~last : req1;
    assign we_sel   = gnt_sel ? we1 : we0;
    assign ready_ok = (cnt >= MIN_LAT_C) && mem_ready;

    always_comb begin
        state_nx = state;
        mem_we   = 1'b0;
        mem_rsel = 4'b0000;
        mem_a    = 32'h0;
        mem_wd   = 32'h0;
        done0    = 1'b0;
        done1    = 1'b0;
        err      = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nx = we_sel ? WR : RD_WAIT;
                end
            end
            WR: begin
                mem_we   = 1'b1;
                mem_a    = addr_q;
                mem_wd   = wd_q;
                state_nx = DONE;
            end
            RD_WAIT: begin
                mem_rsel = 4'b0011;
                mem_a    = addr_q;
                if (ready_ok || (cnt == TIMEOUT_C)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done0    = ~gnt;
                done1    = gnt;
                err      = timed_out;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            gnt       <= 1'b0;
            addr_q    <= 32'h0;
            wd_q      <= 32'h0;
            cnt       <= 6'h0;
            timed_out <= 1'b0;
            rline     <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && (req0 || req1)) begin
                gnt    <= gnt_sel;
                addr_q <= gnt_sel ? addr1 : addr0;
                wd_q   <= gnt_sel ? wd1 : wd0;
            end
            if (state == RD_WAIT && state_nx == RD_WAIT) begin
                if (cnt != TIMEOUT_C) begin
                    cnt <= cnt + 6'd1;
                end
            end else begin
                cnt <= 6'h0;
            end
            timed_out <= (state == RD_WAIT) && !ready_ok && (cnt == TIMEOUT_C);
            if (state == RD_WAIT && ready_ok) begin
                rline <= mem_rline;
            end
            if (state == DONE) begin
                last <= gnt;
            end
        end
    end

endmodule
